// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with handshake and a multi-cycle mult/div sequencer.
// Optional macro ALU_CTRL_ILLEGAL_TRAP_EN: illegal R-type funct yields a trap code and the illegal flag.
module alu_ctrl_seq #(
    parameter int unsigned FUNCT_W   = 6,
    parameter int unsigned GOUT_W    = 4,
    parameter int unsigned MD_CYCLES = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluop,
    input  logic [FUNCT_W-1:0] funct,
    output logic               out_valid,
    output logic [GOUT_W-1:0]  gout,
    output logic               out_md,
    output logic               md_start,
    output logic               busy,
    output logic               illegal
);

    localparam int unsigned CNT_W = $clog2(MD_CYCLES + 1);

    typedef enum logic {
        S_IDLE,
        S_MD_BUSY
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              md_start_q, md_start_d;
    logic              out_md_q, out_md_d;
    logic [GOUT_W-1:0] gout_q, gout_d;

    logic [3:0]        dec_code;
    logic              dec_md;
    logic              dec_ill;
    logic              accept;

    // Pure combinational decode of the incoming request.
    always_comb begin
        dec_code = 4'b0010;
        dec_md   = 1'b0;
        dec_ill  = 1'b0;
        unique case (aluop)
            2'b00: dec_code = 4'b0010;
            2'b01: dec_code = 4'b0110;
            2'b11: dec_code = 4'b0001;
            default: begin
                if ((funct >> 6) != '0) begin
                    dec_ill = 1'b1;
                end else begin
                    case (funct[5:0])
                        6'b100100: dec_code = 4'b0000;
                        6'b100101: dec_code = 4'b0001;
                        6'b100000: dec_code = 4'b0010;
                        6'b100110: dec_code = 4'b0011;
                        6'b100111: dec_code = 4'b0100;
                        6'b100010: dec_code = 4'b0110;
                        6'b101010: dec_code = 4'b0111;
                        6'b000000: dec_code = 4'b1010;
                        6'b011000: begin dec_code = 4'b1000; dec_md = 1'b1; end
                        6'b011010: begin dec_code = 4'b1001; dec_md = 1'b1; end
                        default:   dec_ill = 1'b1;
                    endcase
                end
            end
        endcase
    end

    assign accept = in_valid && (state_q == S_IDLE);

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        md_start_d  = 1'b0;
        out_md_d    = out_md_q;
        gout_d      = gout_q;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    out_md_d = dec_md;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    gout_d    = dec_ill ? '1 : GOUT_W'(dec_code);
                    illegal_d = dec_ill;
`else
                    gout_d    = dec_ill ? GOUT_W'(4'b0010) : GOUT_W'(dec_code);
`endif
                    if (dec_md) begin
                        md_start_d = 1'b1;
                        cnt_d      = CNT_W'(MD_CYCLES);
                        state_d    = S_MD_BUSY;
                    end else begin
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_MD_BUSY: begin
                // Result is announced in the cycle after the count reaches 1.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            md_start_q  <= 1'b0;
            out_md_q    <= 1'b0;
            gout_q      <= GOUT_W'(4'b0010);
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            md_start_q  <= md_start_d;
            out_md_q    <= out_md_d;
            gout_q      <= gout_d;
        end
    end

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_MD_BUSY);
    assign out_valid = out_valid_q;
    assign md_start  = md_start_q;
    assign out_md    = out_md_q;
    assign gout      = gout_q;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Scoreboard bench for alu_ctrl_seq with MD_CYCLES=4.
module tb_alu_ctrl_seq;

    localparam int unsigned MD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] aluop = 2'b00;
    logic [5:0] funct = 6'd0;
    logic       in_ready, out_valid, out_md, md_start, busy, illegal;
    logic [3:0] gout;

    alu_ctrl_seq #(
        .FUNCT_W(6),
        .GOUT_W(4),
        .MD_CYCLES(MD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .aluop(aluop),
        .funct(funct),
        .out_valid(out_valid),
        .gout(gout),
        .out_md(out_md),
        .md_start(md_start),
        .busy(busy),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gout;
        logic       md;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   mdl_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t ref_model(input logic [1:0] op, input logic [5:0] f);
        exp_t e;
        e.gout = 4'h2;
        e.md   = 1'b0;
        e.ill  = 1'b0;
        if (op == 2'b01) e.gout = 4'h6;
        else if (op == 2'b11) e.gout = 4'h1;
        else if (op == 2'b10) begin
            case (f)
                6'h24: e.gout = 4'h0;
                6'h25: e.gout = 4'h1;
                6'h20: e.gout = 4'h2;
                6'h26: e.gout = 4'h3;
                6'h27: e.gout = 4'h4;
                6'h22: e.gout = 4'h6;
                6'h2a: e.gout = 4'h7;
                6'h00: e.gout = 4'ha;
                6'h18: begin e.gout = 4'h8; e.md = 1'b1; end
                6'h1a: begin e.gout = 4'h9; e.md = 1'b1; end
                default: begin
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
                    e.gout = 4'hf;
                    e.ill  = 1'b1;
`else
                    e.gout = 4'h2;
`endif
                end
            endcase
        end
        return e;
    endfunction

    task automatic step(input logic v, input logic [1:0] op, input logic [5:0] f);
        exp_t e;
        in_valid = v;
        aluop    = op;
        funct    = f;
        @(posedge clk);
        if (reset) begin
            mdl_cnt = 0;
            sb.delete();
        end else if (v && mdl_cnt == 0) begin
            e = ref_model(op, f);
            sb.push_back(e);
            if (e.md) mdl_cnt = MD;
        end else if (mdl_cnt > 0) begin
            mdl_cnt--;
        end
        #1;
    endtask

    // Output monitor: pops the scoreboard on every out_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check_eq("in_ready", in_ready, mdl_cnt == 0);
            check_eq("busy", busy, mdl_cnt != 0);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_eq("gout", gout, e.gout);
                    check_eq("out_md", out_md, e.md);
                    check_eq("illegal", illegal, e.ill);
                end
            end
        end
    end

    logic [1:0] seq_op[4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    logic [5:0] rnd_f[12] = '{6'h24, 6'h25, 6'h20, 6'h26, 6'h27, 6'h22,
                              6'h2a, 6'h00, 6'h18, 6'h1a, 6'h3f, 6'h01};

    initial begin
        step(0, 2'b00, 6'h00);
        step(0, 2'b00, 6'h00);
        reset = 1'b0;
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_gout", gout, 4'h2);
        check_eq("rst_md_start", md_start, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_illegal", illegal, 0);
        check_eq("rst_out_md", out_md, 0);
        check_eq("rst_in_ready", in_ready, 1);

        step(1, 2'b10, 6'h22);
        check_eq("sub_out_valid", out_valid, 1);
        check_eq("sub_in_ready", in_ready, 1);

        for (int i = 0; i < 4; i++) begin
            step(1, seq_op[i], 6'h2a);
            check_eq("b2b_out_valid", out_valid, 1);
        end
        step(0, 2'b00, 6'h00);
        check_eq("b2b_idle", out_valid, 0);

        step(1, 2'b10, 6'h18);
        check_eq("mul_md_start", md_start, 1);
        check_eq("mul_busy", busy, 1);
        check_eq("mul_in_ready", in_ready, 0);
        check_eq("mul_no_ov", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 2'b00, 6'h00);
            check_eq("mul_md_start_once", md_start, 0);
            check_eq("mul_busy_hold", busy, 1);
            check_eq("mul_no_ov_busy", out_valid, 0);
        end
        step(0, 2'b00, 6'h00);
        check_eq("mul_done_ov", out_valid, 1);
        check_eq("mul_done_gout", gout, 4'h8);
        check_eq("mul_done_md", out_md, 1);
        check_eq("mul_done_busy", busy, 0);
        step(0, 2'b00, 6'h00);
        check_eq("mul_no_extra_ov", out_valid, 0);

        step(1, 2'b10, 6'h1a);
        step(0, 2'b00, 6'h00);
        reset = 1'b1;
        step(0, 2'b00, 6'h00);
        reset = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_gout", gout, 4'h2);
        for (int i = 0; i < MD + 2; i++) begin
            step(0, 2'b00, 6'h00);
            check_eq("abort_no_ov", out_valid, 0);
        end

        step(1, 2'b10, 6'h3f);
        check_eq("ill_out_valid", out_valid, 1);
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
        check_eq("ill_flag", illegal, 1);
        check_eq("ill_gout", gout, 4'hf);
`else
        check_eq("ill_flag", illegal, 0);
        check_eq("ill_gout", gout, 4'h2);
`endif

        reset = 1'b1;
        step(1, 2'b00, 6'h00);
        reset = 1'b0;
        check_eq("rstv_no_ov", out_valid, 0);
        check_eq("rstv_in_ready", in_ready, 1);
        step(0, 2'b00, 6'h00);
        check_eq("rstv_no_ov_late", out_valid, 0);

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 rnd_f[$urandom_range(0, 11)]);
        end
        for (int i = 0; i < MD + 2; i++) step(0, 2'b00, 6'h00);
        check_eq("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
